// File: rtl/fpadd_align.sv
// FP32 adder operand-alignment pre-stage: orders operands by magnitude, then
// right-shifts the smaller mantissa by the exponent difference with G/R/S bits.
module fpadd_align #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      reg_A,
  input  logic [31:0]      reg_B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic             out_eff_sub,
  output logic [7:0]       out_exp,
  output logic [26:0]      out_mant_big,
  output logic [26:0]      out_mant_small,
  output logic             out_zero,
  output logic [CNT_W-1:0] op_count
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high. valid never depends on ready; in_ready depends on out_ready
  // combinationally so a full pipe can drain and refill in the same edge.
  logic s1_valid_q, s2_valid_q;
  logic s1_adv, s2_adv, in_fire, s2_load;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;
  assign in_fire  = in_valid && in_ready;
  assign s2_load  = s1_valid_q && s2_adv;

  // Stage 1 next-state: magnitude compare on {exp, frac}; tie makes A big.
  logic        a_big;
  logic [31:0] big_op, small_op;
  logic [7:0]  diff_d;
  logic        zero_d;

  always_comb begin
    a_big    = (reg_A[30:0] >= reg_B[30:0]);
    big_op   = a_big ? reg_A : reg_B;
    small_op = a_big ? reg_B : reg_A;
    diff_d   = big_op[30:23] - small_op[30:23];
    zero_d   = (reg_A[31] ^ reg_B[31]) && (reg_A[30:0] == reg_B[30:0]);
  end

  logic        s1_sign_q, s1_eff_sub_q, s1_zero_q;
  logic [7:0]  s1_exp_q, s1_diff_q;
  logic [23:0] s1_mant_big_q, s1_mant_small_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q      <= 1'b0;
      s1_sign_q       <= 1'b0;
      s1_eff_sub_q    <= 1'b0;
      s1_zero_q       <= 1'b0;
      s1_exp_q        <= 8'd0;
      s1_diff_q       <= 8'd0;
      s1_mant_big_q   <= 24'd0;
      s1_mant_small_q <= 24'd0;
    end else begin
      if (s1_adv) s1_valid_q <= in_valid;
      if (in_fire) begin
        s1_sign_q       <= big_op[31];
        s1_eff_sub_q    <= reg_A[31] ^ reg_B[31];
        s1_zero_q       <= zero_d;
        s1_exp_q        <= big_op[30:23];
        s1_diff_q       <= diff_d;
        s1_mant_big_q   <= {1'b1, big_op[22:0]};
        s1_mant_small_q <= {1'b1, small_op[22:0]};
      end
    end
  end

  // Stage 2 next-state: shift with sticky collapse of every bit shifted out.
  logic [26:0] small_ext, shifted, lost_mask, mant_small_d, mant_big_d;

  always_comb begin
    small_ext    = {s1_mant_small_q, 3'b000};
    mant_big_d   = {s1_mant_big_q, 3'b000};
    shifted      = small_ext >> s1_diff_q[4:0];
    lost_mask    = ~(27'h7FFFFFF << s1_diff_q[4:0]);
    mant_small_d = {shifted[26:1], shifted[0] | (|(small_ext & lost_mask))};
    if (s1_diff_q >= 8'd27) mant_small_d = 27'h0000001;
  end

  logic             out_sign_q, out_eff_sub_q, out_zero_q;
  logic [7:0]       out_exp_q;
  logic [26:0]      out_mant_big_q, out_mant_small_q;
  logic [CNT_W-1:0] op_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_q       <= 1'b0;
      out_sign_q       <= 1'b0;
      out_eff_sub_q    <= 1'b0;
      out_zero_q       <= 1'b0;
      out_exp_q        <= 8'd0;
      out_mant_big_q   <= 27'd0;
      out_mant_small_q <= 27'd0;
      op_count_q       <= '0;
    end else begin
      if (s2_adv) s2_valid_q <= s1_valid_q;
      if (s2_load) begin
        out_sign_q       <= s1_sign_q;
        out_eff_sub_q    <= s1_eff_sub_q;
        out_zero_q       <= s1_zero_q;
        out_exp_q        <= s1_exp_q;
        out_mant_big_q   <= mant_big_d;
        out_mant_small_q <= mant_small_d;
      end
      if (s2_valid_q && out_ready) op_count_q <= op_count_q + CNT_W'(1);
    end
  end

  assign out_valid      = s2_valid_q;
  assign out_sign       = out_sign_q;
  assign out_eff_sub    = out_eff_sub_q;
  assign out_zero       = out_zero_q;
  assign out_exp        = out_exp_q;
  assign out_mant_big   = out_mant_big_q;
  assign out_mant_small = out_mant_small_q;
  assign op_count       = op_count_q;

endmodule

// File: tb/tb_fpadd_align.sv
// Directed bench for fpadd_align: hand-computed alignment vectors, latency,
// throughput, backpressure, random output stalls and mid-operation reset.
module tb_fpadd_align;
  localparam int CNT_W = 16;
  localparam int NV    = 9;

  logic             clk, reset, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]      reg_A, reg_B;
  logic             out_sign, out_eff_sub, out_zero;
  logic [7:0]       out_exp;
  logic [26:0]      out_mant_big, out_mant_small;
  logic [CNT_W-1:0] op_count;

  fpadd_align #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .reg_A(reg_A), .reg_B(reg_B), .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_eff_sub(out_eff_sub), .out_exp(out_exp),
    .out_mant_big(out_mant_big), .out_mant_small(out_mant_small),
    .out_zero(out_zero), .op_count(op_count)
  );

  // Observed result word: {sign, eff_sub, exp, mant_big, mant_small, zero}
  logic [64:0] obs_word;
  assign obs_word = {out_sign, out_eff_sub, out_exp, out_mant_big, out_mant_small, out_zero};

  logic [31:0] va [NV] = '{32'h3F800000, 32'h3F800000, 32'hBF800000,
                           32'h4B800000, 32'h4F800000, 32'hC0400000,
                           32'h4C000000, 32'h3F800000, 32'h3F800000};
  logic [31:0] vb [NV] = '{32'h3F800000, 32'h40000000, 32'h3F800000,
                           32'h3F800001, 32'h3F800000, 32'h3FC00000,
                           32'h3F800000, 32'hC1200000, 32'hBF800000};
  logic [64:0] vexp [NV] = '{
    {1'b0, 1'b0, 8'h7F, 27'h4000000, 27'h4000000, 1'b0},
    {1'b0, 1'b0, 8'h80, 27'h4000000, 27'h2000000, 1'b0},
    {1'b1, 1'b1, 8'h7F, 27'h4000000, 27'h4000000, 1'b1},
    {1'b0, 1'b0, 8'h97, 27'h4000000, 27'h0000005, 1'b0},
    {1'b0, 1'b0, 8'h9F, 27'h4000000, 27'h0000001, 1'b0},
    {1'b1, 1'b1, 8'h80, 27'h6000000, 27'h3000000, 1'b0},
    {1'b0, 1'b0, 8'h98, 27'h4000000, 27'h0000002, 1'b0},
    {1'b1, 1'b1, 8'h82, 27'h5000000, 27'h0800000, 1'b0},
    {1'b0, 1'b1, 8'h7F, 27'h4000000, 27'h4000000, 1'b1}};

  logic [64:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drive_pair(input int i);
    in_valid = 1'b1; reg_A = va[i]; reg_B = vb[i];
  endtask

  task automatic test_reset();
    reset = 1'b1; out_ready = 1'b1; drive_pair(0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_vec++; if (obs_word !== 65'd0) begin n_err++; $display("FAIL reset_fields: got %h want 0", obs_word); end
    n_vec++; if (op_count !== 16'd0) begin n_err++; $display("FAIL reset_op_count: got %0d want 0", op_count); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_no_accept c%0d: out_valid %b want 0", k, out_valid); end
    end
  endtask

  task automatic test_align();
    logic [CNT_W-1:0] cnt;
    do_reset();
    cnt = '0; out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive_pair(i); #1;
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL align%0d_in_ready: got %b want 1", i, in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL align%0d_early: out_valid %b want 0", i, out_valid); end
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL align%0d_latency: out_valid %b want 1", i, out_valid); end
      n_vec++; if (obs_word !== vexp[i]) begin n_err++; $display("FAIL align%0d_result: got %h want %h", i, obs_word, vexp[i]); end
      @(negedge clk);
      cnt = cnt + 1'b1;
      n_vec++; if (op_count !== cnt) begin n_err++; $display("FAIL align%0d_op_count: got %0d want %0d", i, op_count, cnt); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL align%0d_dup: out_valid %b want 0", i, out_valid); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    exp_q.delete(); out_ready = 1'b1;
    for (int c = 0; c < NV + 2; c++) begin
      @(negedge clk);
      if (c < NV) begin
        drive_pair(c); exp_q.push_back(vexp[c]); #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready c%0d: got %b want 1", c, in_ready); end
      end else begin
        in_valid = 1'b0; #1;
      end
      if (c >= 2) begin
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid c%0d: got %b want 1", c, out_valid); end
        n_vec++; if (obs_word !== exp_q[0]) begin n_err++; $display("FAIL b2b_result c%0d: got %h want %h", c, obs_word, exp_q[0]); end
        void'(exp_q.pop_front());
      end
    end
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: out_valid %b want 0", out_valid); end
    n_vec++; if (op_count !== 16'(NV)) begin n_err++; $display("FAIL b2b_op_count: got %0d want %0d", op_count, NV); end
  endtask

  task automatic test_backpressure();
    int bp [4] = '{1, 3, 5, 7};
    do_reset();
    exp_q.delete(); out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive_pair(bp[(c < 2) ? c : 2]); #1;
      if (c < 2) begin
        exp_q.push_back(vexp[bp[c]]);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_accept c%0d: in_ready %b want 1", c, in_ready); end
      end else begin
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full c%0d: in_ready %b want 0", c, in_ready); end
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid c%0d: got %b want 1", c, out_valid); end
        n_vec++; if (obs_word !== vexp[bp[0]]) begin n_err++; $display("FAIL bp_stable c%0d: got %h want %h", c, obs_word, vexp[bp[0]]); end
      end
    end
    out_ready = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (d > 0) @(negedge clk);
      if (d < 2) drive_pair(bp[d + 2]); else in_valid = 1'b0;
      #1;
      if (d < 2) begin
        exp_q.push_back(vexp[bp[d + 2]]);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release d%0d: in_ready %b want 1", d, in_ready); end
      end
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_drain_valid d%0d: got %b want 1", d, out_valid); end
      n_vec++; if (obs_word !== exp_q[0]) begin n_err++; $display("FAIL bp_order d%0d: got %h want %h", d, obs_word, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    @(negedge clk);
    n_vec++; if (op_count !== 16'd4) begin n_err++; $display("FAIL bp_op_count: got %0d want 4", op_count); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty: out_valid %b want 0", out_valid); end
  endtask

  task automatic test_random_stall();
    int idx, got, cyc;
    logic stalled;
    logic [64:0] held;
    do_reset();
    exp_q.delete(); idx = 0; got = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (got < NV && cyc < 300) begin
      @(negedge clk);
      if (stalled) begin
        n_vec++; if (out_valid !== 1'b1 || obs_word !== held) begin n_err++; $display("FAIL stall_hold cyc%0d: got %b/%h want 1/%h", cyc, out_valid, obs_word, held); end
      end
      out_ready = 1'($urandom_range(0, 1));
      if (idx < NV) drive_pair(idx); else in_valid = 1'b0;
      #1;
      if (out_valid && out_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL stall_extra cyc%0d: got %h want none", cyc, obs_word); end
        else begin
          if (obs_word !== exp_q[0]) begin n_err++; $display("FAIL stall_result cyc%0d: got %h want %h", cyc, obs_word, exp_q[0]); end
          void'(exp_q.pop_front());
        end
        got++;
      end
      stalled = out_valid && !out_ready;
      held = obs_word;
      if (in_valid && in_ready) begin exp_q.push_back(vexp[idx]); idx++; end
      cyc++;
    end
    n_vec++; if (got < NV) begin n_err++; $display("FAIL stall_timeout: got %0d results want %0d", got, NV); end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    n_vec++; if (op_count !== 16'(NV)) begin n_err++; $display("FAIL stall_op_count: got %0d want %0d", op_count, NV); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive_pair(c);
    end
    @(negedge clk);
    out_ready = 1'b0; drive_pair(3);
    n_vec++; if (op_count !== 16'd1) begin n_err++; $display("FAIL mid_pre_count: got %0d want 1", op_count); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
    n_vec++; if (obs_word !== 65'd0) begin n_err++; $display("FAIL mid_fields: got %h want 0", obs_word); end
    n_vec++; if (op_count !== 16'd0) begin n_err++; $display("FAIL mid_op_count: got %0d want 0", op_count); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_stale c%0d: out_valid %b want 0", k, out_valid); end
    end
    @(negedge clk);
    drive_pair(5);
    @(negedge clk);
    in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_new_early: out_valid %b want 0", out_valid); end
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mid_new_valid: got %b want 1", out_valid); end
    n_vec++; if (obs_word !== vexp[5]) begin n_err++; $display("FAIL mid_new_result: got %h want %h", obs_word, vexp[5]); end
    @(negedge clk);
    n_vec++; if (op_count !== 16'd1) begin n_err++; $display("FAIL mid_new_count: got %0d want 1", op_count); end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; reg_A = '0; reg_B = '0;
    test_reset();
    test_align();
    test_back_to_back();
    test_backpressure();
    test_random_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
